tri_fu_mul_bthenc_seq: RTL and testbench

TRI_FU_MUL_BTHENC_SEQ -- requirements
Module: tri_fu_mul_bthenc_seq

---
 rtl/tri_fu_mul_bthenc_seq.sv | 101 ++++++++++
 tb/tb_tri_fu_mul_bthenc_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tri_fu_mul_bthenc_seq.sv
// Sequential radix-4 Booth encoder: captures a multiplier operand and
// streams one Booth digit (sneg/sx/sx2 controls + index) per handshake.
// Ports: nclk, rst (async, active-high); ld_val/ld_rdy/ld_data operand in;
//        dig_val/dig_rdy digit handshake; dig_sneg, dig_sx, dig_sx2,
//        dig_idx (weight 4^k), dig_last.
// Macro TRI_FU_BTHENC_SIGNED_EN: operand is two's complement, WIDTH/2
// digits. Undefined: operand unsigned, WIDTH/2+1 digits.
module tri_fu_mul_bthenc_seq #(
   parameter int WIDTH = 16,
   localparam int IW   = $clog2(WIDTH/2+1)
) (
   input  logic             nclk,
   input  logic             rst,
   input  logic             ld_val,
   output logic             ld_rdy,
   input  logic [WIDTH-1:0] ld_data,
   output logic             dig_val,
   input  logic             dig_rdy,
   output logic             dig_sneg,
   output logic             dig_sx,
   output logic             dig_sx2,
   output logic [IW-1:0]    dig_idx,
   output logic             dig_last
);

`ifdef TRI_FU_BTHENC_SIGNED_EN
   localparam int NDIG = WIDTH/2;
`else
   localparam int NDIG = WIDTH/2 + 1;
`endif
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIG-1);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   op_q;
   logic [IW-1:0]      idx_q;
   logic [WIDTH+2:0]   ext;
   logic [2:0]         trip;
   logic               is_last;
   logic               ld_fire;
   logic               dig_fire;

   // Operand padded with b[-1]=0 below and two zeros above, so the
   // extra unsigned digit sees {0,0,b[WIDTH-1]}.
   assign ext     = {2'b00, op_q, 1'b0};
   assign trip    = 3'(ext >> {idx_q, 1'b0});
   assign is_last = (idx_q == LAST_IDX);

   always_ff @(posedge nclk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge nclk or posedge rst) begin
      if (rst) begin
         op_q  <= '0;
         idx_q <= '0;
      end else if (ld_fire) begin
         op_q  <= ld_data;
         idx_q <= '0;
      end else if (dig_fire) begin
         idx_q <= is_last ? '0 : idx_q + IW'(1);
      end
   end

   always_comb begin
      state_d  = state_q;
      ld_rdy   = 1'b0;
      dig_val  = 1'b0;
      dig_sneg = 1'b0;
      dig_sx   = 1'b0;
      dig_sx2  = 1'b0;
      dig_idx  = '0;
      dig_last = 1'b0;
      ld_fire  = 1'b0;
      dig_fire = 1'b0;
      unique case (state_q)
         IDLE: begin
            ld_rdy  = 1'b1;
            ld_fire = ld_val;
            if (ld_val) state_d = SCAN;
         end
         SCAN: begin
            dig_val  = 1'b1;
            dig_sneg = trip[2];
            dig_sx   = trip[1] ^ trip[0];
            // x2 only for +2 (011) and -2 (100); 111 is -0.
            dig_sx2  = (trip == 3'b011) | (trip == 3'b100);
            dig_idx  = idx_q;
            dig_last = is_last;
            dig_fire = dig_rdy;
            if (dig_rdy && is_last) state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_tri_fu_mul_bthenc_seq.sv
// Bench for tri_fu_mul_bthenc_seq (WIDTH=16), scoreboard of expected
// Booth digits plus reconstruction of the operand value from digits.
module tb_tri_fu_mul_bthenc_seq;

   localparam int W  = 16;
   localparam int IW = $clog2(W/2+1);
`ifdef TRI_FU_BTHENC_SIGNED_EN
   localparam int NDIG = W/2;
   localparam bit SGN  = 1'b1;
`else
   localparam int NDIG = W/2 + 1;
   localparam bit SGN  = 1'b0;
`endif

   logic          nclk = 1'b0;
   logic          rst;
   logic          ld_val;
   logic          ld_rdy;
   logic [W-1:0]  ld_data;
   logic          dig_val;
   logic          dig_rdy;
   logic          dig_sneg;
   logic          dig_sx;
   logic          dig_sx2;
   logic [IW-1:0] dig_idx;
   logic          dig_last;

   int n_run  = 0;
   int n_fail = 0;

   logic [7:0]   exp_q[$];
   logic [W-1:0] opv_q[$];
   int           acc = 0;
   bit           stall_prev = 0;
   logic [7:0]   held;

   tri_fu_mul_bthenc_seq #(.WIDTH(W)) dut (
      .nclk    (nclk),
      .rst     (rst),
      .ld_val  (ld_val),
      .ld_rdy  (ld_rdy),
      .ld_data (ld_data),
      .dig_val (dig_val),
      .dig_rdy (dig_rdy),
      .dig_sneg(dig_sneg),
      .dig_sx  (dig_sx),
      .dig_sx2 (dig_sx2),
      .dig_idx (dig_idx),
      .dig_last(dig_last)
   );

   always #5 nclk = ~nclk;

   task automatic chk(input string tag, input int got, input int expv);
      n_run++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, expv);
      end
   endtask

   function automatic logic [7:0] dig_vec();
      logic [7:0] v;
      v = {dig_sneg, dig_sx, dig_sx2, dig_last, 4'(dig_idx)};
      return v;
   endfunction

   // Expected digits from the Booth digit value d = -2*b2 + b1 + b0.
   function automatic void gen(input logic [W-1:0] op);
      logic [W+2:0] b;
      logic [2:0]   t;
      int           d;
      logic         sx;
      logic         sx2;
      logic         lst;
      b = {2'b00, op, 1'b0};
      for (int k = 0; k < NDIG; k++) begin
         t   = {b[2*k+2], b[2*k+1], b[2*k]};
         d   = -2*int'(t[2]) + int'(t[1]) + int'(t[0]);
         sx  = (d == 1) || (d == -1);
         sx2 = (d == 2) || (d == -2);
         lst = (k == NDIG-1);
         exp_q.push_back({t[2], sx, sx2, lst, 4'(k)});
      end
      opv_q.push_back(op);
   endfunction

   always @(negedge nclk) begin
      logic [7:0] got;
      logic [7:0] e;
      logic [W-1:0] o;
      int dv;
      int ov;
      if (rst !== 1'b0) begin
         stall_prev = 0;
      end else begin
         got = dig_vec();
         if (stall_prev) chk("hold", int'(got), int'(held));
         if (dig_val) chk("sx_sx2_excl", int'(dig_sx & dig_sx2), 0);
         if (dig_val && dig_rdy) begin
            if (exp_q.size() == 0) begin
               chk("spurious_digit", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("digit", int'(got), int'(e));
               dv = int'(dig_sx) + 2*int'(dig_sx2);
               if (dig_sneg) dv = -dv;
               acc += dv * (1 << (2*int'(dig_idx)));
               if (dig_last && opv_q.size() != 0) begin
                  o  = opv_q.pop_front();
                  ov = SGN ? int'($signed(o)) : int'(o);
                  chk("value", acc, ov);
                  acc = 0;
               end
            end
         end
         stall_prev = dig_val && !dig_rdy;
         held       = got;
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!ld_rdy && n < 200) begin
         @(posedge nclk); #1;
         n++;
      end
      if (!ld_rdy) chk("idle_timeout", 0, 1);
   endtask

   task automatic do_load(input logic [W-1:0] v);
      wait_idle();
      ld_val  = 1'b1;
      ld_data = v;
      @(posedge nclk);
      gen(v);
      #1;
      ld_val  = 1'b0;
      ld_data = W'($urandom);
   endtask

   task automatic load_timed(input logic [W-1:0] v);
      int n = 0;
      do_load(v);
      chk("lat1_val", int'(dig_val), 1);
      chk("lat1_idx", int'(dig_idx), 0);
      chk("lat1_rdy", int'(ld_rdy), 0);
      while (!ld_rdy && n < 100) begin
         @(posedge nclk); #1;
         n++;
      end
      chk("busy_cycles", n, NDIG);
   endtask

   initial begin
      int n;
      rst     = 1'b1;
      ld_val  = 1'b0;
      ld_data = '0;
      dig_rdy = 1'b1;
      #1;
      chk("rst_ld_rdy", int'(ld_rdy), 1);
      chk("rst_dig", int'({dig_val, dig_vec()}), 0);
      @(posedge nclk); #1;
      rst = 1'b0;

      load_timed(16'h0003);
      load_timed(16'hFFFF);
      load_timed(16'h8000);
      load_timed(16'h0000);
      load_timed(16'h7FFF);
      load_timed(16'h5555);

      // backpressure at digit 1
      do_load(16'h0003);
      @(posedge nclk); #1;
      chk("bp_idx1", int'(dig_idx), 1);
      dig_rdy = 1'b0;
      repeat (3) @(posedge nclk);
      #1;
      chk("bp_held_idx", int'(dig_idx), 1);
      chk("bp_held_val", int'(dig_val), 1);
      dig_rdy = 1'b1;
      @(posedge nclk); #1;
      chk("bp_adv_idx", int'(dig_idx), 2);
      wait_idle();

      // reset in the middle of a scan at index 4
      do_load(16'h1234);
      n = 0;
      while (!(dig_val && dig_idx == 4) && n < 50) begin
         @(negedge nclk);
         n++;
      end
      chk("reach_idx4", int'(dig_idx), 4);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_dig_val", int'(dig_val), 0);
      chk("arst_ld_rdy", int'(ld_rdy), 1);
      chk("arst_idx", int'(dig_idx), 0);
      exp_q.delete();
      opv_q.delete();
      acc = 0;
      @(posedge nclk); #1;
      rst = 1'b0;
      chk("post_rst_rdy", int'(ld_rdy), 1);
      load_timed(16'h0003);

      // ld_val held through the scan with changing data
      ld_val  = 1'b1;
      ld_data = 16'h00F3;
      @(posedge nclk);
      gen(16'h00F3);
      #1;
      n = 0;
      while (!ld_rdy && n < 100) begin
         ld_data = W'($urandom);
         @(posedge nclk); #1;
         n++;
      end
      ld_val = 1'b0;
      chk("hold_ld_busy", n, NDIG);

      // random operands with random downstream stalls
      for (int i = 0; i < 20; i++) begin
         do_load(W'($urandom));
         n = 0;
         while (!ld_rdy && n < 200) begin
            dig_rdy = 1'($urandom_range(0, 1));
            @(posedge nclk); #1;
            n++;
         end
         dig_rdy = 1'b1;
      end
      wait_idle();
      @(posedge nclk); #1;
      chk("sb_empty", exp_q.size(), 0);
      chk("idle_dig", int'({dig_val, dig_vec()}), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
